fp32_add_checker: RTL and testbench
===================================

Name: fp32_add_checker

Overview:
- Hardware result checker for the single-precision adder. It is the receiving end of the adder's result stream.
- Expected sums are queued in an internal FIFO. Each adder result is paired in order with the oldest expected value and compared within an ULP tolerance.
- Totals, mismatch count and the first failing pair are latched for readback, so a regression needs no result-file dump.
- Sits beside the adder in the test harness, fed by the same vector source that drives a/b.

Parameters:
- DEPTH, 16, expected-value FIFO entries (power of 2, ≥2)
- ULP_TOL, 0, max allowed |ordered(got) − ordered(exp)|; 0 means bit-exact except ±0 and NaN rules
- CNT_W, 16, width of the vector and mismatch counters

Ports:
- MAIN_CLK  in  1  clock, rising edge
- MAIN_RST_N  in  1  asynchronous active-low reset
- start  in  1  pulse; arms a run of n_vectors comparisons
- n_vectors  in  CNT_W  comparisons in the run, sampled on start
- exp_valid  in  1  push exp_data into FIFO
- exp_data  in  32  expected IEEE754 sum
- exp_ready  out  1  FIFO not full
- dut_valid  in  1  adder result present
- dut_data  in  32  adder result (ab)
- busy  out  1  run in progress
- done  out  1  run finished; sticky until next start
- pass  out  1  done & mism_cnt==0 & no errors
- total_cnt  out  CNT_W  comparisons completed
- mism_cnt  out  CNT_W  mismatches
- first_idx  out  CNT_W  index (0-based) of first mismatch
- first_got  out  32  dut_data of first mismatch
- first_exp  out  32  exp_data of first mismatch
- ovf_err  out  1  sticky: push while full
- unf_err  out  1  sticky: dut_valid while FIFO empty

Behaviour:
- Reset: all outputs 0 except exp_ready=1. FIFO empty, FSM IDLE, all counters and captures 0.
- A reset mid-run discards the FIFO contents and the run.
- FSM states:
  - IDLE: waits for start.
  - RUN: active comparisons.
  - DRAIN: waits for the compare pipeline to empty.
  - DONE: results held.
- FSM transitions:
  - start in IDLE or DONE → RUN. Clears counters, captures, errors and FIFO; latches n_vectors.
  - start with n_vectors==0 → DONE directly, pass=1.
  - start while busy is ignored.
- FIFO:
  - Show-ahead FIFO with DEPTH entries.
  - Pushes are accepted in any state except IDLE.
  - Push while full: data dropped, ovf_err set.
  - Push and pop in the same cycle is allowed, including when full (pop frees the slot first) or empty with no pop possible (push only).
- Compare stage 1 (cycle of dut_valid in RUN):
  - If the FIFO is non-empty, pop the head and register the pair plus the match flag.
  - If the FIFO is empty, set unf_err, do no compare and do not advance the count.
  - dut_valid outside RUN is ignored.
- Match rules:
  - NaN is exp==8'hFF with mantissa≠0.
  - Both NaN → match. Exactly one NaN → mismatch.
  - Otherwise ord(x) = sign ? −x[30:0] : x[30:0], as 33-bit signed.
  - match iff |ord(got)−ord(exp)| ≤ ULP_TOL.
  - +0 and −0 therefore match. Inf compares as the next ordered step above max finite.
- Compare stage 2 (next edge):
  - total_cnt increments.
  - On mismatch, mism_cnt increments, saturating at all-ones.
  - On the first mismatch only, first_idx, first_got and first_exp load.
- Run end:
  - When the stage-1 compare count reaches n_vectors, go to DRAIN.
  - The final stage-2 update lands the next cycle. done rises one cycle after that.
  - Latency: done is high 2 cycles after the edge sampling the last dut_valid.
- Results stay stable in DONE until the next start.

Decomposition:
- Shared package fp32_chk_pkg:
  - FSM state enum.
  - NaN/sign/exponent field constants (EXP_MSB=30, EXP_LSB=23, MAN_W=23).
  - Function ord33(x) used by the compare.
- One sub-module: fp32_chk_fifo, a synchronous show-ahead FIFO with full/empty and async active-low reset.

Test Plan:
- n_vectors=3; exp 3F800000, 40000000, C0400000; dut identical, one per cycle → done 2 cycles after last dut, total_cnt=3, mism_cnt=0, pass=1.
- n_vectors=2; exp 3F800000, 40000000; dut 3F800000, 40000001; ULP_TOL=0 → mism_cnt=1, first_idx=1, first_got=40000001, first_exp=40000000, pass=0. Rerun with ULP_TOL=1 → pass=1.
- Zero and NaN rules (n_vectors=3): exp 00000000 vs dut 80000000 → match; exp 7FC00000 vs dut 7F800001 → match; exp 7F800000 vs dut 7FC00000 → mismatch → mism_cnt=1.
- Push DEPTH+1 expected values with no dut → exp_ready=0 after DEPTH pushes, ovf_err=1. Push and pop in the same cycle when full → no overflow.
- dut_valid before any exp push → unf_err=1, total_cnt stays 0. Assert MAIN_RST_N=0 mid-run → all outputs return to reset values immediately, and a new start works normally.
- start with n_vectors=0 → done=1, pass=1 the next cycle. start pulsed while busy → ignored, run completes with the original count.

Source files
------------

// File: rtl/fp32_chk_pkg.sv
// Shared types, field positions and compare helpers for the fp32 adder result checker.
package fp32_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W   = 23;

  // Exponent all ones with a non-zero mantissa; infinities are not NaN.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'hFF) && (x[MAN_W-1:0] != '0);
  endfunction

  // Maps an IEEE754 pattern onto a monotonic signed integer line, so ULP
  // distance is a plain subtraction and +0/-0 both land on zero.
  function automatic logic signed [32:0] ord33(input logic [31:0] x);
    logic signed [32:0] mag;
    mag = {2'b00, x[30:0]};
    return x[31] ? -mag : mag;
  endfunction

endpackage

// File: rtl/fp32_chk_fifo.sv
// Show-ahead FIFO holding expected sums; head is valid whenever not empty.
module fp32_chk_fifo
  import fp32_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         wr_en, rd_en;

  // Extra pointer bit separates full from empty at equal indices.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over any concurrent push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp32_add_checker.sv
// Pairs adder results with queued expected sums, compares within ULP_TOL and
// latches totals, mismatch count and the first failing pair.
module fp32_add_checker
  import fp32_chk_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ULP_TOL = 0,
  parameter int CNT_W   = 16
) (
  input  logic             MAIN_CLK,
  input  logic             MAIN_RST_N,
  input  logic             start,
  input  logic [CNT_W-1:0] n_vectors,
  input  logic             exp_valid,
  input  logic [31:0]      exp_data,
  output logic             exp_ready,
  input  logic             dut_valid,
  input  logic [31:0]      dut_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [31:0]      first_got,
  output logic [31:0]      first_exp,
  output logic             ovf_err,
  output logic             unf_err
);
  localparam logic [33:0] TOL34 = 34'(ULP_TOL);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   n_lat, cmp_cnt;
  logic               start_ok, push, pop, full, empty;
  logic [31:0]        head;
  logic               s1_vld, s1_match;
  logic [31:0]        s1_got, s1_exp;
  logic               nan_g, nan_e, match;
  logic signed [32:0] ord_g, ord_e;
  logic [33:0]        diff, adiff;

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign push     = exp_valid && (state != ST_IDLE);
  assign pop      = dut_valid && (state == ST_RUN) && !empty;

  fp32_chk_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (MAIN_CLK),
    .rst_n (MAIN_RST_N),
    .clr   (start_ok),
    .push  (push),
    .pop   (pop),
    .wdata (exp_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Stage-1 match decision against the FIFO head.
  always_comb begin
    ord_g = ord33(dut_data);
    ord_e = ord33(head);
    diff  = {ord_g[32], ord_g} - {ord_e[32], ord_e};
    adiff = diff[33] ? (34'd0 - diff) : diff;
    nan_g = is_nan(dut_data);
    nan_e = is_nan(head);
    match = (nan_g && nan_e) || (!nan_g && !nan_e && (adiff <= TOL34));
  end

  // State register.
  always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
    if (!MAIN_RST_N) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next state: DRAIN holds until the last registered pair has been counted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = (n_vectors == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (pop && ((cmp_cnt + CNT_W'(1)) == n_lat)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_vld) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Run length latch and stage-1 pop counter.
  always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
    if (!MAIN_RST_N) begin
      n_lat   <= '0;
      cmp_cnt <= '0;
    end else if (start_ok) begin
      n_lat   <= n_vectors;
      cmp_cnt <= '0;
    end else if (pop) begin
      cmp_cnt <= cmp_cnt + CNT_W'(1);
    end
  end

  // Stage 1: register the popped pair and its match flag.
  always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
    if (!MAIN_RST_N) begin
      s1_vld   <= 1'b0;
      s1_match <= 1'b0;
      s1_got   <= '0;
      s1_exp   <= '0;
    end else begin
      s1_vld <= pop;
      if (pop) begin
        s1_got   <= dut_data;
        s1_exp   <= head;
        s1_match <= match;
      end
    end
  end

  // Stage 2: counters and first-mismatch capture.
  always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
    if (!MAIN_RST_N) begin
      total_cnt <= '0;
      mism_cnt  <= '0;
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
    end else if (start_ok) begin
      total_cnt <= '0;
      mism_cnt  <= '0;
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
    end else if (s1_vld) begin
      total_cnt <= total_cnt + CNT_W'(1);
      if (!s1_match) begin
        if (mism_cnt != '1) mism_cnt <= mism_cnt + CNT_W'(1);
        if (mism_cnt == '0) begin
          first_idx <= total_cnt;
          first_got <= s1_got;
          first_exp <= s1_exp;
        end
      end
    end
  end

  // Sticky stream errors, cleared by an accepted start.
  always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
    if (!MAIN_RST_N) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (start_ok) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (push && full && !pop)                   ovf_err <= 1'b1;
      if (dut_valid && (state == ST_RUN) && empty) unf_err <= 1'b1;
    end
  end

  assign exp_ready = !full;
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign pass      = done && (mism_cnt == '0) && !ovf_err && !unf_err;

endmodule

// File: tb/tb_fp32_add_checker.sv
// Randomized bench with a transaction-level reference model for two checker
// instances (ULP_TOL 0 and 1) fed by the same stream.
module tb_fp32_add_checker;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CNT_W-1:0] n_vectors = '0;
  logic exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic dut_valid = 1'b0;
  logic [31:0] dut_data = '0;

  logic exp_ready [2];
  logic busy [2];
  logic done [2];
  logic pass [2];
  logic ovf_err [2];
  logic unf_err [2];
  logic [CNT_W-1:0] total_cnt [2];
  logic [CNT_W-1:0] mism_cnt [2];
  logic [CNT_W-1:0] first_idx [2];
  logic [31:0] first_got [2];
  logic [31:0] first_exp [2];

  always #5 clk = ~clk;

  fp32_add_checker #(.DEPTH(DEPTH), .ULP_TOL(0), .CNT_W(CNT_W)) d0 (
    .MAIN_CLK(clk), .MAIN_RST_N(rst_n), .start(start), .n_vectors(n_vectors),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready[0]),
    .dut_valid(dut_valid), .dut_data(dut_data), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .total_cnt(total_cnt[0]), .mism_cnt(mism_cnt[0]),
    .first_idx(first_idx[0]), .first_got(first_got[0]), .first_exp(first_exp[0]),
    .ovf_err(ovf_err[0]), .unf_err(unf_err[0]));

  fp32_add_checker #(.DEPTH(DEPTH), .ULP_TOL(1), .CNT_W(CNT_W)) d1 (
    .MAIN_CLK(clk), .MAIN_RST_N(rst_n), .start(start), .n_vectors(n_vectors),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready[1]),
    .dut_valid(dut_valid), .dut_data(dut_data), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .total_cnt(total_cnt[1]), .mism_cnt(mism_cnt[1]),
    .first_idx(first_idx[1]), .first_got(first_got[1]), .first_exp(first_exp[1]),
    .ovf_err(ovf_err[1]), .unf_err(unf_err[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0h, want %0h", nm, k, $time, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned q[$];
  bit m_active, m_done, m_ovf, m_unf, pend, mb;
  int m_left, m_drain, m_total;
  int m_mism [2];
  int m_fidx [2];
  int unsigned m_fgot [2];
  int unsigned m_fexp [2];
  int unsigned pend_got, pend_exp;
  int tol [2] = '{0, 1};

  function automatic bit fp_nan(input int unsigned x);
    return (((x >> 23) & 32'hFF) == 32'hFF) && ((x & 32'h007F_FFFF) != 0);
  endfunction

  function automatic longint ordv(input int unsigned x);
    longint mag;
    mag = longint'(x & 32'h7FFF_FFFF);
    return ((x >> 31) != 0) ? -mag : mag;
  endfunction

  function automatic bit fp_match(input int unsigned g, input int unsigned e, input int t);
    longint d;
    if (fp_nan(g) && fp_nan(e)) return 1'b1;
    if (fp_nan(g) || fp_nan(e)) return 1'b0;
    d = ordv(g) - ordv(e);
    if (d < 0) d = -d;
    return d <= longint'(t);
  endfunction

  task automatic model_clear();
    q.delete();
    m_total = 0;
    for (int k = 0; k < 2; k++) begin
      m_mism[k] = 0; m_fidx[k] = 0; m_fgot[k] = 0; m_fexp[k] = 0;
    end
    m_ovf = 0; m_unf = 0; pend = 0; m_drain = 0; m_left = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_active = 0;
    m_done = 0;
  endtask

  // One step per clock: last cycle's pair is counted, then the new cycle's
  // start / pop / push take effect.
  always @(posedge clk) begin
    if (rst_n) begin
      mb = (m_left > 0) || (m_drain > 0);
      if (pend) begin
        for (int k = 0; k < 2; k++) begin
          if (!fp_match(pend_got, pend_exp, tol[k])) begin
            if (m_mism[k] == 0) begin
              m_fidx[k] = m_total; m_fgot[k] = pend_got; m_fexp[k] = pend_exp;
            end
            if (m_mism[k] < (1 << CNT_W) - 1) m_mism[k]++;
          end
        end
        m_total++;
        pend = 0;
      end
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_done = 1;
      end
      if (start && !mb) begin
        model_clear();
        m_active = 1;
        m_left = int'(n_vectors);
        m_done = (n_vectors == 0);
      end else begin
        if (m_left > 0 && dut_valid) begin
          if (q.size() > 0) begin
            pend = 1; pend_got = dut_data; pend_exp = q.pop_front();
            m_left--;
            if (m_left == 0) m_drain = 2;
          end else begin
            m_unf = 1;
          end
        end
        if (m_active && exp_valid) begin
          if (q.size() < DEPTH) q.push_back(exp_data);
          else m_ovf = 1;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk("exp_ready", k, exp_ready[k], q.size() < DEPTH);
        chk("busy", k, busy[k], (m_left > 0) || (m_drain > 0));
        chk("done", k, done[k], m_done);
        chk("pass", k, pass[k], m_done && (m_mism[k] == 0) && !m_ovf && !m_unf);
        chk("total_cnt", k, total_cnt[k], m_total);
        chk("mism_cnt", k, mism_cnt[k], m_mism[k]);
        chk("first_idx", k, first_idx[k], m_fidx[k]);
        chk("first_got", k, first_got[k], m_fgot[k]);
        chk("first_exp", k, first_exp[k], m_fexp[k]);
        chk("ovf_err", k, ovf_err[k], m_ovf);
        chk("unf_err", k, unf_err[k], m_unf);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned ea[$];
  int unsigned da[$];

  task automatic drive(input bit st, input int nv, input bit ev, input int unsigned ed,
                       input bit dv, input int unsigned dd);
    start = st; n_vectors = CNT_W'(nv);
    exp_valid = ev; exp_data = ed; dut_valid = dv; dut_data = dd;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done[0] && c < budget) begin
      drive(0, 0, 0, 0, 0, 0);
      c++;
    end
    chk("done_within_budget", 0, done[0], 1);
  endtask

  task automatic pair(input int unsigned e, input int unsigned d);
    ea.push_back(e); da.push_back(d);
  endtask

  // Start, push one expected per cycle, results trailing by one cycle.
  task automatic run_pairs();
    int n = ea.size();
    drive(1, n, 0, 0, 0, 0);
    for (int i = 0; i <= n; i++)
      drive(0, 0, i < n, (i < n) ? ea[i] : 0, i > 0, (i > 0) ? da[i-1] : 0);
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 2; k++) begin
      chk("rst_exp_ready", k, exp_ready[k], 1);
      chk("rst_flags", k, {busy[k], done[k], pass[k], ovf_err[k], unf_err[k]}, 0);
      chk("rst_cnts", k, {total_cnt[k], mism_cnt[k], first_idx[k]}, 0);
      chk("rst_first", k, {first_got[k], first_exp[k]}, 0);
    end
  endtask

  function automatic int unsigned rnd_fp();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
      3: return 32'h7F80_0000 | ($urandom_range(0, 1) << 31);
      default: return $urandom;
    endcase
  endfunction

  function automatic int unsigned rnd_got(input int unsigned e);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return e;
      4: return e + 1;
      5: return e - 1;
      6: return e + 2;
      7: return e ^ 32'h8000_0000;
      8: return 32'h7F7F_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pi, di, guard;
    bit ev, dv;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Three exact matches; done two cycles after the last result edge.
    ea.delete(); da.delete();
    pair(32'h3F80_0000, 32'h3F80_0000);
    pair(32'h4000_0000, 32'h4000_0000);
    pair(32'hC040_0000, 32'hC040_0000);
    run_pairs();
    chk("lat_done_e0", 0, done[0], 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lat_done_e1", 0, done[0], 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lat_done_e2", 0, done[0], 1);
    chk("A_total", 0, total_cnt[0], 3);
    chk("A_pass", 0, pass[0], 1);

    // One-ULP miss: fails at tolerance 0, passes at tolerance 1.
    ea.delete(); da.delete();
    pair(32'h3F80_0000, 32'h3F80_0000);
    pair(32'h4000_0000, 32'h4000_0001);
    run_pairs();
    wait_done(10);
    chk("B_mism", 0, mism_cnt[0], 1);
    chk("B_first_idx", 0, first_idx[0], 1);
    chk("B_first_got", 0, first_got[0], 32'h4000_0001);
    chk("B_first_exp", 0, first_exp[0], 32'h4000_0000);
    chk("B_pass", 0, pass[0], 0);
    chk("B_pass_tol1", 1, pass[1], 1);

    // Signed zero and NaN rules.
    ea.delete(); da.delete();
    pair(32'h0000_0000, 32'h8000_0000);
    pair(32'h7FC0_0000, 32'h7F80_0001);
    pair(32'h7F80_0000, 32'h7FC0_0000);
    run_pairs();
    wait_done(10);
    chk("Z_mism", 0, mism_cnt[0], 1);
    chk("Z_first_idx", 0, first_idx[0], 2);
    chk("Z_mism_tol1", 1, mism_cnt[1], 1);

    // Overflow: DEPTH+1 pushes with no results.
    drive(1, 4, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 32'h4100_0000 + i, 0, 0);
    chk("O_ready_full", 0, exp_ready[0], 0);
    chk("O_ovf_before", 0, ovf_err[0], 0);
    drive(0, 0, 1, 32'h4200_0000, 0, 0);
    chk("O_ovf", 0, ovf_err[0], 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 32'h4100_0000 + i);
    wait_done(10);
    chk("O_pass", 0, pass[0], 0);

    // Push and pop together while full: no overflow.
    drive(1, DEPTH + 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 32'h4300_0000 + i, 0, 0);
    drive(0, 0, 1, 32'h4300_0000 + DEPTH, 1, 32'h4300_0000);
    chk("F_ovf", 0, ovf_err[0], 0);
    chk("F_ready", 0, exp_ready[0], 0);
    for (int i = 1; i <= DEPTH; i++) drive(0, 0, 0, 0, 1, 32'h4300_0000 + i);
    wait_done(10);
    chk("F_total", 0, total_cnt[0], DEPTH + 1);
    chk("F_pass", 0, pass[0], 1);

    // Underflow, then reset mid-run.
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h3F80_0000);
    chk("U_unf", 0, unf_err[0], 1);
    chk("U_total", 0, total_cnt[0], 0);
    drive(0, 0, 1, 32'h3F80_0000, 0, 0);
    drive(0, 0, 1, 32'h4000_0000, 1, 32'h3F80_0000);
    start = 0; exp_valid = 0; dut_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    ea.delete(); da.delete();
    pair(32'h3F80_0000, 32'h3F80_0000);
    pair(32'hBF80_0000, 32'hBF80_0000);
    run_pairs();
    wait_done(10);
    chk("R_total", 0, total_cnt[0], 2);
    chk("R_pass", 0, pass[0], 1);

    // Zero-length run.
    drive(1, 0, 0, 0, 0, 0);
    chk("N0_done", 0, done[0], 1);
    chk("N0_pass", 0, pass[0], 1);

    // Start while busy is ignored.
    drive(1, 3, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h4040_0000, 0, 0);
    drive(1, 5, 1, 32'h4080_0000, 1, 32'h4040_0000);
    drive(0, 0, 1, 32'h40A0_0000, 1, 32'h4080_0000);
    drive(0, 0, 0, 0, 1, 32'h40A0_0000);
    wait_done(10);
    chk("SB_total", 0, total_cnt[0], 3);
    chk("SB_pass", 0, pass[0], 1);

    // Randomized runs with random push/result timing.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 40);
      ea.delete(); da.delete();
      for (int i = 0; i < n; i++) begin
        int unsigned e;
        e = rnd_fp();
        pair(e, rnd_got(e));
      end
      drive(1, n, 0, 0, 0, 0);
      pi = 0; di = 0; guard = 0;
      while ((pi < n || di < n) && guard < 1000) begin
        ev = (pi < n) && ($urandom_range(0, 3) != 0);
        dv = (di < pi) && ($urandom_range(0, 2) != 0);
        if (ev && (pi - di) >= DEPTH && !dv) ev = 0;
        drive(0, 0, ev, ev ? ea[pi] : 0, dv, dv ? da[di] : 0);
        if (ev) pi++;
        if (dv) di++;
        guard++;
      end
      wait_done(10);
    end

    drive(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
